// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard slice (package sb_pkg):
// register-file geometry, the late-result hold buffer state encoding and
// a one-hot helper that never marks x0.
package sb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } buf_state_t;

    // One-hot register mask; x0 is hardwired to zero so it never appears
    // in the busy mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (idx != '0) begin
            mask[idx] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/late_hold_buf.sv
// Single-entry hold buffer for multi-cycle results that lose the register
// file write port to an in-order pipe write. EMPTY accepts a late result;
// if the pipe owns the port that cycle the result is captured (HELD) and
// drained in the first cycle the pipe leaves the port free.
module late_hold_buf
    import sb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we,
    input  logic                  late_valid,
    input  logic [REG_ADDR_W-1:0] late_rd,
    input  logic [DATA_W-1:0]     late_wd,
    output logic                  late_ready,
    output logic                  held_valid,
    output logic [REG_ADDR_W-1:0] held_rd,
    output logic [DATA_W-1:0]     held_wd
);

    buf_state_t            state_q, state_d;
    logic                  late_ready_q, late_ready_d;
    logic                  held_valid_q, held_valid_d;
    logic [REG_ADDR_W-1:0] held_rd_q, held_rd_d;
    logic [DATA_W-1:0]     held_wd_q, held_wd_d;

    // Next-state: capture only when a late result arrives while the pipe
    // owns the port; release as soon as the pipe does not write.
    always_comb begin
        state_d   = state_q;
        held_rd_d = held_rd_q;
        held_wd_d = held_wd_q;
        case (state_q)
            EMPTY: begin
                if (late_valid && pipe_we) begin
                    state_d   = HELD;
                    held_rd_d = late_rd;
                    held_wd_d = late_wd;
                end
            end
            HELD: begin
                if (!pipe_we) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        late_ready_d = (state_d == EMPTY);
        held_valid_d = (state_d == HELD);
    end

    // State and registered outputs; reset discards any held entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            late_ready_q <= 1'b1;
            held_valid_q <= 1'b0;
            held_rd_q    <= '0;
            held_wd_q    <= '0;
        end else begin
            state_q      <= state_d;
            late_ready_q <= late_ready_d;
            held_valid_q <= held_valid_d;
            held_rd_q    <= held_rd_d;
            held_wd_q    <= held_wd_d;
        end
    end

    assign late_ready = late_ready_q;
    assign held_valid = held_valid_q;
    assign held_rd    = held_rd_q;
    assign held_wd    = held_wd_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard with write-port arbitration between the in-order
// pipe writeback and a multi-cycle unit. Tracks registers with pending
// long-latency writes, stalls decode on RAW/WAW/full, and owns the
// register-file write port (sampled on negedge by the register file).
// Optional build macro SCOREBOARD_PERF_EN adds saturating stall_cycles
// and late_conflicts counters.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_long,
    input  logic                  issue_uses_rs1,
    input  logic                  issue_uses_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_stall,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0]     pipe_wd,
    input  logic                  late_valid,
    input  logic [REG_ADDR_W-1:0] late_rd,
    input  logic [DATA_W-1:0]     late_wd,
    output logic                  late_ready,
    output logic                  rf_we3,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0]     rf_wd3,
    output logic [NUM_REGS-1:0]   busy_mask
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [15:0]           late_conflicts
`endif
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [PEND_W-1:0]     pending_q, pending_d;

    logic                  held_valid;
    logic [REG_ADDR_W-1:0] held_rd;
    logic [DATA_W-1:0]     held_wd;

    logic                  late_hs;
    logic                  late_capture;
    logic                  late_commit;
    logic [REG_ADDR_W-1:0] late_commit_rd;

    logic                  raw_hit;
    logic                  waw_hit;
    logic                  full_hit;
    logic                  issue_accept;
    logic                  long_accept;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   clr_mask;

    late_hold_buf u_hold (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .late_valid (late_valid),
        .late_rd    (late_rd),
        .late_wd    (late_wd),
        .late_ready (late_ready),
        .held_valid (held_valid),
        .held_rd    (held_rd),
        .held_wd    (held_wd)
    );

    assign late_hs      = late_valid & late_ready;
    assign late_capture = late_hs & pipe_we;

    // Write-port arbitration: pipe first, then the held entry, then a
    // fresh late result passing straight through. x0 is never written.
    always_comb begin
        rf_we3         = 1'b0;
        rf_rd          = pipe_rd;
        rf_wd3         = pipe_wd;
        late_commit    = 1'b0;
        late_commit_rd = '0;
        if (pipe_we) begin
            rf_we3 = (pipe_rd != '0);
        end else if (held_valid) begin
            rf_rd          = held_rd;
            rf_wd3         = held_wd;
            rf_we3         = (held_rd != '0);
            late_commit    = (held_rd != '0);
            late_commit_rd = held_rd;
        end else if (late_hs) begin
            rf_rd          = late_rd;
            rf_wd3         = late_wd;
            rf_we3         = (late_rd != '0);
            late_commit    = (late_rd != '0);
            late_commit_rd = late_rd;
        end
    end

    // Hazard detection against the registered busy mask only; a register
    // being cleared this cycle still stalls for one more cycle.
    always_comb begin
        raw_hit  = (issue_uses_rs1 && (issue_rs1 != '0) && busy_q[issue_rs1]) ||
                   (issue_uses_rs2 && (issue_rs2 != '0) && busy_q[issue_rs2]);
        waw_hit  = (issue_rd != '0) && busy_q[issue_rd];
        full_hit = issue_long && (pending_q == PEND_MAX);
    end

    assign issue_stall  = issue_valid & (raw_hit | waw_hit | full_hit);
    assign issue_accept = issue_valid & ~issue_stall;
    assign long_accept  = issue_accept & issue_long;

    // Busy mask update: clear on late commit, set on accepted long issue;
    // set is applied last so it wins on the same index.
    always_comb begin
        set_mask = long_accept ? reg_onehot(issue_rd) : '0;
        clr_mask = late_commit ? reg_onehot(late_commit_rd) : '0;
        busy_d   = (busy_q & ~clr_mask) | set_mask;
    end

    // Outstanding long-op count; simultaneous increment and decrement
    // cancel, and the count is clamped so it can never wrap.
    always_comb begin
        pending_d = pending_q;
        case ({long_accept, late_hs})
            2'b10: if (pending_q != PEND_MAX) pending_d = pending_q + 1'b1;
            2'b01: if (pending_q != '0)       pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign busy_mask = busy_q;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] late_conflicts_q, late_conflicts_d;

    // Saturating event counters: stalled decode cycles and EMPTY->HELD
    // captures of late results.
    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        late_conflicts_d = late_conflicts_q;
        if (issue_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (late_capture && (late_conflicts_q != '1)) begin
            late_conflicts_d = late_conflicts_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q   <= '0;
            late_conflicts_q <= '0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            late_conflicts_q <= late_conflicts_d;
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign late_conflicts = late_conflicts_q;
`else
    logic unused_capture;
    assign unused_capture = late_capture;
`endif

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter MAX_PENDING, default 4, meaning the maximum number of outstanding long-latency ops.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports issue_valid, issue_long, issue_uses_rs1 and issue_uses_rs2, input, 1 bit each: decode-stage issue request and qualifiers.
REQ-005 The block SHALL have ports issue_rs1, issue_rs2 and issue_rd, input, 5 bits each: decode-stage register addresses.
REQ-006 The block SHALL have port issue_stall, output, 1 bit: decode must hold its instruction.
REQ-007 The block SHALL have ports pipe_we (1 bit), pipe_rd (5 bits) and pipe_wd (32 bits), input: in-order writeback request.
REQ-008 The block SHALL have ports late_valid (1 bit), late_rd (5 bits) and late_wd (32 bits), input, plus late_ready, output, 1 bit: valid/ready completion from the multi-cycle unit.
REQ-009 The block SHALL have ports rf_we3 (1 bit), rf_rd (5 bits) and rf_wd3 (32 bits), output: register file write port (WE3, rd, WD3).
REQ-010 The block SHALL have port busy_mask, output, 32 bits: per-register pending-write bits.

Function
REQ-011 Commit SHALL be defined as rf_we3 high with rf_rd != 0; rf_we3 SHALL never be asserted for rf_rd = 0.
REQ-012 The block SHALL drive the write port combinationally; the register file samples it on negedge, so the write lands in the same cycle.
REQ-013 pipe_we SHALL have absolute priority; a pipe write SHALL always commit in its own cycle.
REQ-014 A late result presented with pipe_we=0 and the hold buffer EMPTY SHALL pass straight through and commit the same cycle.
REQ-015 A late result presented with pipe_we=1 and the hold buffer EMPTY SHALL be captured at posedge, with state EMPTY->HELD.
REQ-016 In HELD, late_ready SHALL be 0.
REQ-017 In HELD, the held entry SHALL commit in the first cycle with pipe_we=0, with state HELD->EMPTY at the following posedge.
REQ-018 late_ready SHALL equal (state == EMPTY); a late handshake SHALL be late_valid & late_ready.
REQ-019 issue_stall SHALL be issue_valid & (RAW | WAW | FULL).
REQ-020 RAW SHALL be (uses_rs1 & rs1!=0 & busy[rs1]) | (uses_rs2 & rs2!=0 & busy[rs2]).
REQ-021 WAW SHALL be rd!=0 & busy[rd].
REQ-022 FULL SHALL be issue_long & (pending == MAX_PENDING).
REQ-023 An accepted issue SHALL be issue_valid & !issue_stall.
REQ-024 An accepted long issue with rd!=0 SHALL set busy[rd] at posedge.
REQ-025 An accepted long issue SHALL increment pending, including when rd=0.
REQ-026 A late handshake SHALL decrement pending.
REQ-027 If an increment and a decrement of pending occur in the same cycle, pending SHALL be unchanged.
REQ-028 pending SHALL be $clog2(MAX_PENDING+1) bits wide and SHALL never wrap.
REQ-029 Committing a late result SHALL clear busy[rd] at the next posedge.
REQ-030 Stall evaluation SHALL use registered busy, so a register clearing this cycle stalls one more cycle (no bypass).
REQ-031 If set and clear of busy hit the same index in the same cycle, set SHALL win.
REQ-032 Pipe writes SHALL never modify busy.
REQ-033 A late result with rd=0 SHALL be handshaken and SHALL decrement pending, with no commit and no busy change.

Reset
REQ-034 Asserting rst SHALL immediately force busy=0, pending=0 and state=EMPTY, discarding any held entry.
REQ-035 During and after reset, outputs SHALL be: issue_stall=0 unless inputs demand otherwise, late_ready=1, busy_mask=0, and rf_we3 following pipe_we only.

Configuration
REQ-036 With SCOREBOARD_PERF_EN defined, the block SHALL add output stall_cycles, 32 bits, a saturating count of cycles with issue_stall=1.
REQ-037 With SCOREBOARD_PERF_EN defined, the block SHALL add output late_conflicts, 16 bits, a saturating count of EMPTY->HELD transitions.
REQ-038 With SCOREBOARD_PERF_EN defined, both counters SHALL clear on rst.
REQ-039 Without SCOREBOARD_PERF_EN, the ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-040 Package sb_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, and the enum buf_state_t {EMPTY, HELD}.
REQ-041 The hold buffer and its FSM SHALL be sub-module late_hold_buf; arbitration and the scoreboard stay in reg_scoreboard.

Verification
REQ-042 Test: issue long rd=5, then next cycle issue rs1=5 uses_rs1 -> busy_mask=0x20 and issue_stall=1 until the cycle after late commit of rd=5.
REQ-043 Test: same cycle pipe_we=1 rd=3 wd=0x11 and late_valid rd=7 wd=0x22 -> commit x3=0x11, late_ready=0 next cycle, x7=0x22 commits the following cycle.
REQ-044 Test: four long issues accepted with MAX_PENDING=4 -> fifth long issue_stall=1, and a non-long independent issue is not stalled.
REQ-045 Test: late_valid rd=0 wd=0xFFFF -> rf_we3=0 and pending decrements by 1.
REQ-046 Test: rst asserted while HELD with busy_mask=0x80 -> busy_mask=0 and late_ready=1 immediately, and the held write never commits.
REQ-047 Test: a WAW issue with rd=9 busy -> stalled; a long issue with rd=0 is accepted while busy_mask is unchanged.
